ring_counter_4: RTL and testbench
=================================

# ring_counter_4

One-hot 4-phase ring counter producing the digit-select strobe for the Alarm display multiplexer. A single asserted bit rotates through the four `selector` lines at a rate set by an internal prescaler, so the downstream display driver lights one digit at a time. It sits between the system clock/reset and the seven-segment anode/digit mux logic.

## Interface

- `WIDTH`, default 4: number of ring positions; legal range 2..16.
- `DIV`, default 1: prescaler ratio. The ring advances once every `DIV` clock cycles; legal range 1..2^20.
- `clk`, input, 1 bit: system clock; all state changes on its rising edge.
- `reset`, input, 1 bit: one clock; reset is asynchronous and active-low (`reset` = 0 clears immediately, independent of `clk`).
- `selector`, output, `WIDTH` bits: one-hot digit select, active-high, driven directly from a register.

## Operation

- Internal state consists of:
  - a `WIDTH`-bit ring register, which drives `selector`;
  - a prescaler counter `pcnt` of width max(1, clog2(`DIV`)).
- Reset (`reset` = 0):
  - ring is set to `{0…0,1}`, i.e. 4'b0001;
  - `pcnt` is set to 0;
  - this holds for as long as `reset` is low.
- Prescaler `tick`:
  - `tick` is asserted when `pcnt` == `DIV`-1; at that edge `pcnt` returns to 0.
  - Otherwise `pcnt` increments by 1 each edge.
  - With `DIV` = 1, `tick` is permanently 1.
- Ring advance on `tick`: rotate left by one position, so bit `WIDTH`-1 wraps into bit 0.
  - Sequence for `WIDTH` = 4: 0001 → 0010 → 0100 → 1000 → 0001 …
- No `tick`: the ring holds its value.
- Exactly one `selector` bit is high at all times after reset.
- No enable or load inputs exist; the block free-runs once `reset` is high.

## Timing

- Reset value of `selector` is 4'b0001, with `pcnt` = 0; it is asserted asynchronously, with no clock needed.
- Reset release:
  - The first rising edge with `reset` = 1 counts as prescaler cycle 1.
  - With `DIV` = 1, `selector` changes at that first edge.
  - In general, the first advance occurs at the `DIV`-th edge after release.
- Latency: `selector` changes at the clock edge on which `tick` is true; there is no combinational path from `reset` deassertion to `selector`.
- Each ring position is held for exactly `DIV` clock cycles; a full rotation is `WIDTH`·`DIV` cycles.
- Reset asserted mid-rotation or mid-prescale: `selector` returns to 0001 immediately and `pcnt` returns to 0. The rotation then restarts from position 0 with a full `DIV` wait.
- Wrap-around: from the 1000 state, the next `tick` yields 0001 within the same single edge.

## Configuration

- Macro: `RING_COUNTER_SELFHEAL_EN`.
- Defined:
  - On every rising edge, if the ring register is not exactly one-hot (zero bits set, more than one bit set, or X), the ring reloads 0001 and `pcnt` reloads 0.
  - Recovery completes within one clock cycle, regardless of `tick`.
- Not defined:
  - Pure rotation, with no legality check.
  - An illegal pattern rotates indefinitely; for example, 0011 → 0110 → 1100 → 1001.

## Test plan

- Reset hold: clock with period 100 ns, `reset` = 0 for 100 ns → `selector` = 0001 throughout, including across the rising edge at 50 ns.
- Rotation with `DIV` = 1: release `reset` at 100 ns → `selector` reads 0010 after the edge at 150 ns, 0100 after 250 ns, 1000 after 350 ns, and 0001 after 450 ns.
- Prescale with `DIV` = 3: after release → each value is held for exactly 3 edges; the sequence is 0001 ×3, 0010 ×3, 0100 ×3, 1000 ×3, then 0001.
- Asynchronous reset mid-run: drop `reset` between edges while `selector` = 0100 → `selector` reads 0001 before the next edge. After release, the first advance comes `DIV` edges later.
- One-hot invariant: run 1000 cycles at `DIV` = 1 and `DIV` = 5 → popcount(`selector`) == 1 on every cycle after reset.
- Self-heal (`RING_COUNTER_SELFHEAL_EN` defined): force the ring register to 0110, then release the force → `selector` = 0001 after the next edge. Without the macro, the same stimulus gives 1100 after the next tick.

Source files
------------

// File: rtl/ring_counter_4.sv
// ring_counter_4: one-hot rotating digit select for the alarm display mux.
// A single high bit walks through selector once every DIV clocks.
// Optional feature: define RING_COUNTER_SELFHEAL_EN to make the ring reload
// 0001 on any edge where it is not exactly one-hot.
module ring_counter_4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] selector
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] RING_INIT = WIDTH'(1);
  localparam logic [PW-1:0]    PCNT_LAST = PW'(DIV - 1);

  logic [WIDTH-1:0] ring;
  logic [WIDTH-1:0] ring_nxt;
  logic [PW-1:0]    pcnt;
  logic [PW-1:0]    pcnt_nxt;
  logic             tick_c;

  // Prescaler terminal count; with DIV == 1 every edge is a tick.
  assign tick_c = (DIV == 1) ? 1'b1 : (pcnt == PCNT_LAST);

`ifdef RING_COUNTER_SELFHEAL_EN
  logic ring_legal_c;

  // Exactly one bit set; an X anywhere makes this non-true and forces a reload.
  assign ring_legal_c = (ring != '0) && ((ring & (ring - WIDTH'(1))) == '0);

  // Next state: rotate on tick, reload both registers on an illegal ring.
  always_comb begin
    ring_nxt = ring;
    pcnt_nxt = pcnt;
    if (ring_legal_c) begin
      pcnt_nxt = tick_c ? '0 : (pcnt + PW'(1));
      if (tick_c) begin
        ring_nxt = {ring[WIDTH-2:0], ring[WIDTH-1]};
      end
    end else begin
      ring_nxt = RING_INIT;
      pcnt_nxt = '0;
    end
  end
`else
  // Next state: pure rotation on tick, no legality check.
  always_comb begin
    ring_nxt = ring;
    pcnt_nxt = tick_c ? '0 : (pcnt + PW'(1));
    if (tick_c) begin
      ring_nxt = {ring[WIDTH-2:0], ring[WIDTH-1]};
    end
  end
`endif

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ring <= RING_INIT;
      pcnt <= '0;
    end else begin
      ring <= ring_nxt;
      pcnt <= pcnt_nxt;
    end
  end

  assign selector = ring;

endmodule

// File: tb/tb_ring_counter_4.sv
// Directed bench for ring_counter_4 at DIV = 1, 3 and 5 sharing clock and reset.
module tb_ring_counter_4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sel1;
  logic [3:0] sel3;
  logic [3:0] sel5;

  int n_checks = 0;
  int n_fail   = 0;

  ring_counter_4 #(.WIDTH(4), .DIV(1)) u1 (.clk(clk), .reset(reset), .selector(sel1));
  ring_counter_4 #(.WIDTH(4), .DIV(3)) u3 (.clk(clk), .reset(reset), .selector(sel3));
  ring_counter_4 #(.WIDTH(4), .DIV(5)) u5 (.clk(clk), .reset(reset), .selector(sel5));

  // 100 ns clock, rising edges at 50, 150, 250 ...
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected values after edge k (k = 1..12) following reset release.
  logic [3:0] exp1 [1:12] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                              4'b0010, 4'b0100, 4'b1000, 4'b0001,
                              4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] exp3 [1:12] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                              4'b0010, 4'b0100, 4'b0100, 4'b0100,
                              4'b1000, 4'b1000, 4'b1000, 4'b0001};
  logic [3:0] exp5 [1:12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                              4'b0010, 4'b0010, 4'b0010, 4'b0010,
                              4'b0010, 4'b0100, 4'b0100, 4'b0100};
  // After the mid-run reset pulse, edges 1..5.
  logic [3:0] rx1 [1:5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] rx3 [1:5] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
  logic [3:0] rx5 [1:5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};

  initial begin
    // Reset hold, including across the edge at 50 ns.
    #1 reset = 1'b0;
    #19;
    check("reset_async_d1", sel1, 4'b0001);
    check("reset_async_d3", sel3, 4'b0001);
    check("reset_async_d5", sel5, 4'b0001);
    #40;
    check("reset_hold_edge_d1", sel1, 4'b0001);
    check("reset_hold_edge_d3", sel3, 4'b0001);
    #40;
    reset = 1'b1;
    #1;
    check("release_no_comb_d1", sel1, 4'b0001);

    // Rotation and prescale, 12 edges after release.
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("rot_d1_e%0d", k), sel1, exp1[k]);
      check($sformatf("rot_d3_e%0d", k), sel3, exp3[k]);
      check($sformatf("rot_d5_e%0d", k), sel5, exp5[k]);
    end

    // Two more edges: DIV=1 sits at 0100, DIV=5 is mid-prescale at 0100.
    step();
    step();
    check("pre_areset_d1", sel1, 4'b0100);
    check("pre_areset_d5", sel5, 4'b0100);

    // Asynchronous reset between edges.
    #20 reset = 1'b0;
    #5;
    check("areset_d1", sel1, 4'b0001);
    check("areset_d3", sel3, 4'b0001);
    check("areset_d5", sel5, 4'b0001);
    #5 reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("restart_d1_e%0d", k), sel1, rx1[k]);
      check($sformatf("restart_d3_e%0d", k), sel3, rx3[k]);
      check($sformatf("restart_d5_e%0d", k), sel5, rx5[k]);
    end

    // One-hot invariant over 1000 cycles.
    for (int k = 0; k < 1000; k++) begin
      step();
      check("onehot_d1", 4'($countones(sel1)), 4'd1);
      check("onehot_d5", 4'($countones(sel5)), 4'd1);
    end

    // Corrupt the DIV=1 ring and watch the next two edges.
    force u1.ring = 4'b0110;
    #1;
    release u1.ring;
    #1;
    check("forced_value", sel1, 4'b0110);
    step();
`ifdef RING_COUNTER_SELFHEAL_EN
    check("illegal_e1", sel1, 4'b0001);
    step();
    check("illegal_e2", sel1, 4'b0010);
`else
    check("illegal_e1", sel1, 4'b1100);
    step();
    check("illegal_e2", sel1, 4'b1001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
